// File: rtl/package_settings.sv
// package_settings: system-wide data-path widths shared by the front-end blocks
package package_settings;
    localparam int SIZE_ADC_DATA = 12;
endpackage

// File: rtl/parameter_pulse_gen.sv
// parameter_pulse_gen: shared types and defaults for the synthetic ADC pulse source
package parameter_pulse_gen;
    import package_settings::*;

    typedef enum logic {IDLE, RUN} pg_state_t;

    localparam int DECAY_SHIFT_DEFAULT = 6;
    localparam int FRAC_BITS_DEFAULT   = 8;
    localparam int ACC_W               = SIZE_ADC_DATA + FRAC_BITS_DEFAULT + 1;

    function automatic int acc_width(input int frac_bits);
        return SIZE_ADC_DATA + frac_bits + 1;
    endfunction
endpackage

// File: rtl/pulse_gen_decay.sv
// pulse_gen_decay: exponential-decay accumulator with step injection, clamp and sticky overflow
module pulse_gen_decay
    import package_settings::*;
#(
    parameter int DECAY_SHIFT = 6,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_W       = SIZE_ADC_DATA + FRAC_BITS + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inj,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    output logic [ACC_W-1:0]         acc,
    output logic                     overflow
);
    logic [ACC_W-1:0] acc_q, acc_d, shr, dec;
    logic [ACC_W:0]   sum;
    logic             ovf_q, ovf_d;

    // The sub-LSB tail would stall at acc>>DECAY_SHIFT == 0; force a unit decrement so acc reaches 0
    always_comb begin
        shr   = acc_q >> DECAY_SHIFT;
        dec   = (shr == '0 && acc_q != '0) ? ACC_W'(1) : shr;
        sum   = {1'b0, acc_q - dec} + (inj ? (ACC_W + 1)'(amplitude) << FRAC_BITS : '0);
        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        ovf_d = ovf_q | sum[ACC_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc      = acc_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/adc_pulse_gen.sv
// adc_pulse_gen: synthetic ADC sample source - baseline plus periodic/single decaying pulses
// Holds the run FSM, period counter and output saturation; the accumulator lives in pulse_gen_decay.
module adc_pulse_gen
    import package_settings::*;
    import parameter_pulse_gen::*;
#(
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEFAULT,
    parameter int FRAC_BITS   = FRAC_BITS_DEFAULT,
    parameter int PERIOD_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     single,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    input  logic [PERIOD_W-1:0]      period,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic                     pulse_start,
    output logic                     busy,
    output logic                     overflow
);
    localparam int AW = acc_width(FRAC_BITS);
    localparam int SW = SIZE_ADC_DATA + 2;

    pg_state_t                state_q, state_d;
    logic [PERIOD_W-1:0]      cnt_q, cnt_d;
    logic [SIZE_ADC_DATA-1:0] out_q, out_d;
    logic                     ps_q, busy_q, busy_d, ovf_q, ovf_d;
    logic                     inj_p, inj, acc_ovf, sat;
    logic [AW-1:0]            acc;
    logic [SW-1:0]            sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inj_p   = 1'b0;
        if (state_q == IDLE) begin
            if (enable) begin
                state_d = RUN;
                if (period != '0) begin
                    inj_p = 1'b1;
                    cnt_d = period - PERIOD_W'(1);
                end
            end
        end else if (!enable) begin
            state_d = IDLE;
        end else if (period != '0) begin
            inj_p = cnt_q == '0;
            cnt_d = inj_p ? period - PERIOD_W'(1) : cnt_q - PERIOD_W'(1);
        end
        inj    = inj_p | single;
        sum    = SW'(baseline) + SW'(acc >> FRAC_BITS);
        sat    = sum[SW-1:SIZE_ADC_DATA] != '0;
        out_d  = sat ? '1 : sum[SIZE_ADC_DATA-1:0];
        busy_d = state_q == RUN || acc != '0;
        ovf_d  = ovf_q | acc_ovf | sat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            ps_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ps_q    <= inj;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    pulse_gen_decay #(
        .DECAY_SHIFT(DECAY_SHIFT),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_W      (AW)
    ) u_decay (
        .clk      (clk),
        .reset    (reset),
        .inj      (inj),
        .amplitude(amplitude),
        .acc      (acc),
        .overflow (acc_ovf)
    );

    assign output_data = out_q;
    assign pulse_start = ps_q;
    assign busy        = busy_q;
    assign overflow    = ovf_q;
endmodule
